// File: rtl/vga_timing_if.sv
// Display-side bundle between the timing generator and vga_writer.
// master: timing generator (consumes in_* updates, drives timing and shadow copies).
// slave : update source / vga_writer side (drives in_*, observes timing and shadows).
interface vga_timing_if;
   // update path from state/decode logic
   logic [11:0] in_location;
   logic [11:0] in_move_command;
   logic [3:0]  in_orientation;
   logic [3:0]  in_target_location;
   logic        in_orientation_rdy;
   logic        in_valid;

   // raster timing
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync;
   logic        vsync;
   logic        blank;
   logic        frame_start;

   // frame-stable shadow copies
   logic [11:0] location;
   logic [11:0] move_command;
   logic [3:0]  orientation;
   logic [3:0]  target_location;
   logic        orientation_ready;
   logic        new_data;
   logic [7:0]  overwrite_cnt;

   modport master (
      input  in_location, in_move_command, in_orientation, in_target_location,
             in_orientation_rdy, in_valid,
      output hcount, vcount, hsync, vsync, blank, frame_start,
             location, move_command, orientation, target_location, orientation_ready,
             new_data, overwrite_cnt
   );

   modport slave (
      output in_location, in_move_command, in_orientation, in_target_location,
             in_orientation_rdy, in_valid,
      input  hcount, vcount, hsync, vsync, blank, frame_start,
             location, move_command, orientation, target_location, orientation_ready,
             new_data, overwrite_cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 1024x768 XGA @ 65 MHz) with frame-synchronised
// robot-state shadow registers. Updates strobed in at any time are held and released to
// vga_writer only at the start of vertical blanking (hcount==0, vcount==V_ACTIVE).
// Ports: vclock (pixel clock), reset (sync, active-high), bus (vga_timing_if.master):
//   in_* + in_valid update strobe; hcount/vcount/hsync/vsync/blank/frame_start timing;
//   location/move_command/orientation/target_location/orientation_ready shadows,
//   new_data release pulse, overwrite_cnt saturating count of dropped pending updates.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned H_FP     = 24,
   parameter int unsigned H_SYNC   = 136,
   parameter int unsigned H_BP     = 160,
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned V_FP     = 3,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 29
) (
   input logic          vclock,
   input logic          reset,
   vga_timing_if.master bus
);

   localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_START  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC;

   typedef struct packed {
      logic [11:0] location;
      logic [11:0] move_command;
      logic [3:0]  orientation;
      logic [3:0]  target_location;
      logic        orientation_ready;
   } upd_t;

   typedef enum logic {IDLE, HELD} upd_state_t;

   upd_state_t  state;
   upd_t        pend_buf;
   upd_t        shadow;
   upd_t        in_upd_c;
   logic [10:0] next_h_c;
   logic [9:0]  next_v_c;
   logic        h_wrap_c;
   logic        release_c;

   assign in_upd_c = '{location:          bus.in_location,
                       move_command:      bus.in_move_command,
                       orientation:       bus.in_orientation,
                       target_location:   bus.in_target_location,
                       orientation_ready: bus.in_orientation_rdy};

   // Next raster position; all registered timing outputs are derived from it so they
   // line up with the count shown on the same cycle.
   always_comb begin
      h_wrap_c  = (bus.hcount == 11'(H_TOTAL - 1));
      next_h_c  = h_wrap_c ? 11'd0 : bus.hcount + 11'd1;
      next_v_c  = bus.vcount;
      if (h_wrap_c) begin
         next_v_c = (bus.vcount == 10'(V_TOTAL - 1)) ? 10'd0 : bus.vcount + 10'd1;
      end
      release_c = (next_h_c == 11'd0) && (next_v_c == 10'(V_ACTIVE));
   end

   // Raster counters and sync/blank generation.
   always_ff @(posedge vclock) begin
      if (reset) begin
         bus.hcount      <= '0;
         bus.vcount      <= '0;
         bus.hsync       <= 1'b1;
         bus.vsync       <= 1'b1;
         bus.blank       <= 1'b0;
         bus.frame_start <= 1'b0;
      end else begin
         bus.hcount      <= next_h_c;
         bus.vcount      <= next_v_c;
         bus.hsync       <= !((next_h_c >= 11'(HS_START)) && (next_h_c < 11'(HS_END)));
         bus.vsync       <= !((next_v_c >= 10'(VS_START)) && (next_v_c < 10'(VS_END)));
         bus.blank       <= (next_h_c >= 11'(H_ACTIVE)) || (next_v_c >= 10'(V_ACTIVE));
         bus.frame_start <= (next_h_c == 11'd0) && (next_v_c == 10'd0);
      end
   end

   // Update FSM: release happens first on the edge into the release point, then any
   // strobe sampled on that same edge is captured as fresh pending data (not an overwrite).
   always_ff @(posedge vclock) begin
      if (reset) begin
         state             <= IDLE;
         pend_buf          <= '0;
         shadow            <= '0;
         bus.new_data      <= 1'b0;
         bus.overwrite_cnt <= '0;
      end else begin
         bus.new_data <= 1'b0;
         if (release_c && (state == HELD)) begin
            shadow       <= pend_buf;
            bus.new_data <= 1'b1;
         end
         if (bus.in_valid) begin
            pend_buf <= in_upd_c;
            state    <= HELD;
            if ((state == HELD) && !release_c && (bus.overwrite_cnt != 8'hFF)) begin
               bus.overwrite_cnt <= bus.overwrite_cnt + 8'd1;
            end
         end else if (release_c) begin
            state <= IDLE;
         end
      end
   end

   assign bus.location          = shadow.location;
   assign bus.move_command      = shadow.move_command;
   assign bus.orientation       = shadow.orientation;
   assign bus.target_location   = shadow.target_location;
   assign bus.orientation_ready = shadow.orientation_ready;

endmodule
